// File: rtl/mebra_stream_bf.sv
// Streaming DAS / signed-sqrt DMAS beamformer: one pixel from CHANNELS samples, mode chosen per pixel.
// Latency: last sample accepted at cycle t -> bf_valid at t+SQRT_LAT+3, identical in both modes.
// Backpressure: a held result (bf_valid & ~bf_ready) freezes the whole pipeline and drops s_ready.
module mebra_stream_bf #(
   parameter int CHANNELS = 128,
   parameter int DATA_W   = 16,
   parameter int PIX_W    = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    mode,
   input  logic                                    s_valid,
   output logic                                    s_ready,
   input  logic signed [DATA_W-1:0]                s_data,
   output logic                                    bf_valid,
   input  logic                                    bf_ready,
   output logic signed [DATA_W+2*$clog2(CHANNELS)+1:0] bf_out,
   output logic                                    bf_mode,
   output logic [PIX_W-1:0]                        bf_pix
);
   localparam int CH_W     = $clog2(CHANNELS);
   localparam int SQ_W     = DATA_W / 2;
   localparam int SQRT_LAT = SQ_W;
   localparam int OUT_W    = DATA_W + 2 * CH_W + 2;
   localparam int RW       = SQ_W + 3;   // sqrt remainder width, holds 4*rem + 3
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   logic en;
   assign en      = ~(bf_valid & ~bf_ready);
   assign s_ready = en;

   // channel position and per-pixel mode tag
   logic [CH_W-1:0] cnt;
   logic            pix_mode;
   logic            mode_tag;
   logic [DATA_W-1:0] abs_in;
   assign mode_tag = (cnt == '0) ? mode : pix_mode;
   assign abs_in   = s_data[DATA_W-1] ? (~s_data + DATA_W'(1)) : s_data;

   // sqrt pipeline state and aligned sidebands
   logic [DATA_W-1:0]        rad_q  [SQRT_LAT];
   logic [RW-1:0]            rem_q  [SQRT_LAT];
   logic [SQ_W-1:0]          root_q [SQRT_LAT];
   logic signed [DATA_W-1:0] x_q    [SQRT_LAT];
   logic [DATA_W-1:0]        abs_q  [SQRT_LAT];
   logic [SQRT_LAT-1:0]      vld_q, mode_q, first_q, last_q;

   logic [DATA_W-1:0] rad_i  [SQRT_LAT];
   logic [RW-1:0]     rem_i  [SQRT_LAT];
   logic [SQ_W-1:0]   root_i [SQRT_LAT];
   logic [DATA_W-1:0] rad_n  [SQRT_LAT];
   logic [RW-1:0]     rem_n  [SQRT_LAT];
   logic [SQ_W-1:0]   root_n [SQRT_LAT];
   logic [RW-1:0]     rem_t  [SQRT_LAT];
   logic [RW-1:0]     trial  [SQRT_LAT];

   // route each sqrt stage's inputs: stage 0 starts from |x| with empty root
   always_comb begin
      for (int k = 0; k < SQRT_LAT; k++) begin
         rad_i[k]  = '0;
         rem_i[k]  = '0;
         root_i[k] = '0;
      end
      rad_i[0] = abs_in;
      for (int k = 1; k < SQRT_LAT; k++) begin
         rad_i[k]  = rad_q[k-1];
         rem_i[k]  = rem_q[k-1];
         root_i[k] = root_q[k-1];
      end
   end

   // restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1
   always_comb begin
      for (int k = 0; k < SQRT_LAT; k++) begin
         rem_t[k] = {rem_i[k][RW-3:0], rad_i[k][DATA_W-1 -: 2]};
         trial[k] = {1'b0, root_i[k], 2'b01};
         rad_n[k] = rad_i[k] << 2;
         if (rem_t[k] >= trial[k]) begin
            rem_n[k]  = rem_t[k] - trial[k];
            root_n[k] = {root_i[k][SQ_W-2:0], 1'b1};
         end else begin
            rem_n[k]  = rem_t[k];
            root_n[k] = {root_i[k][SQ_W-2:0], 1'b0};
         end
      end
   end

   // channel counter, mode latch and sqrt pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         pix_mode <= 1'b0;
         vld_q    <= '0;
         mode_q   <= '0;
         first_q  <= '0;
         last_q   <= '0;
         for (int k = 0; k < SQRT_LAT; k++) begin
            rad_q[k]  <= '0;
            rem_q[k]  <= '0;
            root_q[k] <= '0;
            x_q[k]    <= '0;
            abs_q[k]  <= '0;
         end
      end else if (en) begin
         if (s_valid) begin
            cnt <= (cnt == LAST_CH) ? '0 : cnt + CH_W'(1);
            if (cnt == '0) pix_mode <= mode;
         end
         vld_q   <= {vld_q[SQRT_LAT-2:0], s_valid};
         mode_q  <= {mode_q[SQRT_LAT-2:0], mode_tag};
         first_q <= {first_q[SQRT_LAT-2:0], s_valid & (cnt == '0)};
         last_q  <= {last_q[SQRT_LAT-2:0], s_valid & (cnt == LAST_CH)};
         x_q[0]   <= s_data;
         abs_q[0] <= abs_in;
         for (int k = 1; k < SQRT_LAT; k++) begin
            x_q[k]   <= x_q[k-1];
            abs_q[k] <= abs_q[k-1];
         end
         for (int k = 0; k < SQRT_LAT; k++) begin
            rad_q[k]  <= rad_n[k];
            rem_q[k]  <= rem_n[k];
            root_q[k] <= root_n[k];
         end
      end
   end

   // per-sample terms at the sqrt output
   logic signed [OUT_W-1:0] x_ext, abs_ext, sq_ext, s_term;
   assign x_ext   = {{(OUT_W-DATA_W){x_q[SQRT_LAT-1][DATA_W-1]}}, x_q[SQRT_LAT-1]};
   assign abs_ext = {{(OUT_W-DATA_W){1'b0}}, abs_q[SQRT_LAT-1]};
   assign sq_ext  = {{(OUT_W-SQ_W){1'b0}}, root_q[SQRT_LAT-1]};
   assign s_term  = x_q[SQRT_LAT-1][DATA_W-1] ? -sq_ext : sq_ext;

   logic signed [OUT_W-1:0] acc_a, acc_m, acc_s;
   logic                    fin_vld, fin_mode;
   logic signed [OUT_W-1:0] sq_a, sq_m, sq_p;
   logic                    sq_vld, sq_mode;
   logic signed [OUT_W-1:0] dmas;
   assign dmas = sq_p - sq_m;

   // accumulate: first sample of a pixel loads, later ones add; flag finished pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_a    <= '0;
         acc_m    <= '0;
         acc_s    <= '0;
         fin_vld  <= 1'b0;
         fin_mode <= 1'b0;
      end else if (en) begin
         fin_vld  <= vld_q[SQRT_LAT-1] & last_q[SQRT_LAT-1];
         fin_mode <= mode_q[SQRT_LAT-1];
         if (vld_q[SQRT_LAT-1]) begin
            if (first_q[SQRT_LAT-1]) begin
               acc_a <= x_ext;
               acc_m <= abs_ext;
               acc_s <= s_term;
            end else begin
               acc_a <= acc_a + x_ext;
               acc_m <= acc_m + abs_ext;
               acc_s <= acc_s + s_term;
            end
         end
      end
   end

   // square stage: snapshot finished sums so the next pixel can start accumulating
   always_ff @(posedge clk) begin
      if (rst) begin
         sq_vld  <= 1'b0;
         sq_mode <= 1'b0;
         sq_a    <= '0;
         sq_m    <= '0;
         sq_p    <= '0;
      end else if (en) begin
         sq_vld  <= fin_vld;
         sq_mode <= fin_mode;
         sq_a    <= acc_a;
         sq_m    <= acc_m;
         sq_p    <= acc_s * acc_s;
      end
   end

   // output register: hold until accepted, count accepted pixels
   always_ff @(posedge clk) begin
      if (rst) begin
         bf_valid <= 1'b0;
         bf_out   <= '0;
         bf_mode  <= 1'b0;
         bf_pix   <= '0;
      end else if (en) begin
         if (bf_valid & bf_ready) bf_pix <= bf_pix + PIX_W'(1);
         if (sq_vld) begin
            bf_valid <= 1'b1;
            bf_mode  <= sq_mode;
            bf_out   <= sq_mode ? sq_a : {dmas[OUT_W-1], dmas[OUT_W-1:1]};
         end else begin
            bf_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/mebra_stream_bf.md
# mebra_stream_bf

Parametrised, streaming successor to the single-pixel MEBRA core. It accumulates one beamformed pixel from CHANNELS delayed channel samples in either DAS or signed-square-root DMAS mode. The mode is selectable per pixel. Pixels are processed back-to-back with an identical latency in both modes, an internal pipelined square root is used, and valid/ready flow control is provided on input and output. The block sits between the delay/apodisation stage and the image-line buffer.

## Interface
- CHANNELS, 128: samples per pixel; must be ≥2.
- DATA_W, 16: signed input sample width; must be even.
- PIX_W, 16: width of the output pixel index.
- Derived localparams:
  - CH_W = $clog2(CHANNELS)
  - SQ_W = DATA_W/2
  - SQRT_LAT = SQ_W
  - OUT_W = DATA_W+2*CH_W+2
- clk  in  1  single clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  1 = DAS, 0 = DMAS. Sampled only on the first sample of each pixel.
- s_valid  in  1  channel sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  signed channel sample, in channel order 0..CHANNELS-1.
- bf_valid  out  1  result valid. Held until accepted.
- bf_ready  in  1  downstream accepts the result.
- bf_out  out  OUT_W  signed beamformed pixel.
- bf_mode  out  1  mode used for this result.
- bf_pix  out  PIX_W  pixel index. Starts at 0 and wraps modulo 2^PIX_W.

## Operation
- A sample is accepted when s_valid & s_ready.
- The channel counter runs 0..CHANNELS-1 over accepted samples and wraps to 0. The sample accepted at count CHANNELS-1 is tagged last.
- On an accepted sample at count 0, mode is latched into a per-pixel tag. Mode changes at any other time have no effect on the pixel in progress.
- Each accepted sample enters a pipeline of SQRT_LAT stages together with its tags (mode, first, last):
  - |x| is computed as DATA_W unsigned bits, so -2^(DATA_W-1) maps to 2^(DATA_W-1).
  - The sign bit is carried alongside.
  - The square root is an unrolled restoring integer sqrt giving floor(sqrt(|x|)), SQ_W bits.
  - The raw x is delayed to stay aligned with the sqrt output.
- Accumulate stage:
  - On a first-tagged sample, the accumulators load the sample's terms. Otherwise they add to the running values.
  - A = Σx, signed.
  - M = Σ|x|, unsigned.
  - S = Σ s_i, signed, where s_i = -sqrt|x| if x<0, else +sqrt|x|.
- On a last-tagged sample, the pixel is finalised through two more stages:
  - Square stage: P = S·S.
  - Output stage, DAS: bf_out = sign-extended A.
  - Output stage, DMAS: bf_out = (P − M) >>> 1, an arithmetic shift (floor).
- All intermediates are full-width; no saturation is applied. OUT_W is wide enough for every input.
- Pipeline advance: en = ~(bf_valid & ~bf_ready). Every stage, counter and accumulator holds when en=0. s_ready = en.
- bf_valid is set when a finalised pixel reaches the output stage with en=1. It is cleared when the result is accepted and no new result arrives in the same cycle.
- bf_pix increments on each accepted result.

## Timing
- Reset values:
  - s_ready = 1 (combinational from en).
  - bf_valid = 0, bf_out = 0, bf_mode = 0, bf_pix = 0.
  - Channel counter, accumulators and all pipeline valid/tag bits = 0.
- Latency: the last sample of a pixel accepted at cycle t, with no stalls, gives bf_valid=1 at cycle t+SQRT_LAT+3. This is the same in DAS and DMAS.
- Throughput is one sample per cycle. The first sample of pixel n+1 may be accepted the cycle after the last sample of pixel n, with no bubble and no cross-pixel contamination.
- Stall: with bf_valid=1 and bf_ready=0:
  - s_ready=0 in the same cycle.
  - bf_out, bf_mode and bf_pix are stable.
  - Pipeline contents are preserved.
- Simultaneous accept of the output and arrival of a new result: bf_valid stays 1 and bf_out updates.
- Gaps in s_valid insert bubbles. Accumulators change only on valid pipeline entries.
- rst mid-pixel or during a stall discards all partial pixels and the held result. The next accepted sample is channel 0 of pixel index 0.

## Test plan
- CHANNELS=4, DAS, x={100,-20,7,1} → bf_out=88, bf_mode=1, bf_pix=0, bf_valid exactly SQRT_LAT+3 cycles after the last sample.
- CHANNELS=4, DMAS, x={16,9,-4,1} → s={4,3,-2,1}, S=6, M=30 → bf_out=3. Then x={2,2,2,2} back-to-back → bf_out=4, bf_pix=1.
- CHANNELS=4, DATA_W=16, DMAS, x=−32768 ×4 → s=−181 each, S=−724, P=524176, M=131072 → bf_out=196552.
- Alternate DAS/DMAS pixels with no gap, and toggle mode mid-pixel → each result uses the mode sampled at channel 0, and bf_mode matches.
- Hold bf_ready=0 for 20 cycles while streaming → s_ready=0 from the first held cycle, no sample lost, results emerge in order with correct values once released.
- Assert rst after 2 of 4 samples, then send a full pixel {1,2,3,4} in DAS → only bf_out=10 appears, with bf_pix=0.
